// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use / control-operand stalls,
// redirect flush, memory freeze and saturating perf counters.
module hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int CNT_W          = 4,
  parameter int LD_USE_STALL   = 1,
  parameter int LD_CTRL_STALL  = 2,
  parameter int ALU_CTRL_STALL = 1,
  parameter int PERF_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch,
  input  logic              id_jal,
  input  logic              id_jalr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_br_taken,
  input  logic              id_pred_taken,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_busy,
  output logic              stall,
  output logic              freeze,
  output logic              flush,
  output logic              mispredict,
  output logic [CNT_W-1:0]  stall_remaining,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LDC = CNT_W'(LD_CTRL_STALL);
  localparam logic [CNT_W-1:0] C_LDU = CNT_W'(LD_USE_STALL);
  localparam logic [CNT_W-1:0] C_ALC = CNT_W'(ALU_CTRL_STALL);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] haz_n;

  logic ctrl;
  logic rs1_hit;
  logic rs2_hit;
  logic any_hit;
  logic ld_ctrl;
  logic ld_use;
  logic alu_ctrl;
  logic no_haz;
  logic br_miss;

  logic [PERF_W-1:0] stall_cyc_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Operand match against EX and stall length, highest priority first.
  always_comb begin
    ctrl     = id_branch | id_jalr;
    rs1_hit  = id_uses_rs1 && (ex_rd != '0)
               && (ex_rd == id_rs1);
    rs2_hit  = id_uses_rs2 && !id_jalr
               && (ex_rd != '0)
               && (ex_rd == id_rs2);
    any_hit  = rs1_hit | rs2_hit;
    ld_ctrl  = ex_mem_read & ctrl & any_hit;
    ld_use   = ex_mem_read & ~ctrl & any_hit;
    alu_ctrl = ~ex_mem_read & ex_reg_write
               & ctrl & any_hit;
    no_haz   = ~(ld_ctrl | ld_use | alu_ctrl);
    haz_n    = '0;
    unique case (1'b1)
      ld_ctrl:  haz_n = C_LDC;
      ld_use:   haz_n = C_LDU;
      alu_ctrl: haz_n = C_ALC;
      no_haz:   haz_n = '0;
    endcase
  end

  // Stall countdown state and remaining-cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, stall and freeze; mem_busy holds the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    freeze  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (mem_busy) begin
      freeze = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (haz_n != '0) begin
            stall = 1'b1;
            if (haz_n > C_ONE) begin
              state_d = COUNT;
              cnt_d   = haz_n - C_ONE;
            end
          end
        end
        COUNT: begin
          stall = 1'b1;
          if (cnt_q <= C_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
      endcase
    end
  end

  // Redirect only once operands are valid and the pipe moves.
  always_comb begin
    flush      = 1'b0;
    mispredict = 1'b0;
    br_miss    = id_branch
                 && (id_br_taken != id_pred_taken);
    if (!rst && !mem_busy && !stall) begin
      if (br_miss) begin
        flush      = 1'b1;
        mispredict = 1'b1;
      end else if (id_jalr) begin
        flush      = 1'b1;
      end else if (id_jal && !id_pred_taken) begin
        flush      = 1'b1;
        mispredict = 1'b1;
      end
    end
  end

  // Saturating stall-cycle and flush counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cyc_q))
        stall_cyc_q <= stall_cyc_q + PERF_W'(1);
      if (flush && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_remaining = cnt_q;
  assign perf_stall_cyc  = stall_cyc_q;
  assign perf_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a
// 3-cycle load/control, 4-bit-counter instance.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_branch, id_jal, id_jalr;
  logic       id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       id_br_taken, id_pred_taken;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_busy;

  logic        stall, freeze, flush, misp;
  logic [3:0]  rem;
  logic [15:0] pst, pfl;

  logic        s2, fz2, fl2, mp2;
  logic [3:0]  rem2;
  logic [3:0]  pst2, pfl2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_branch(id_branch), .id_jal(id_jal),
    .id_jalr(id_jalr),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_br_taken(id_br_taken),
    .id_pred_taken(id_pred_taken),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_busy(mem_busy),
    .stall(stall), .freeze(freeze),
    .flush(flush), .mispredict(misp),
    .stall_remaining(rem),
    .perf_stall_cyc(pst),
    .perf_flush_cnt(pfl)
  );

  hazard_ctrl #(
    .LD_CTRL_STALL(3),
    .PERF_W(4)
  ) dut2 (
    .clk(clk), .rst(rst),
    .id_branch(id_branch), .id_jal(id_jal),
    .id_jalr(id_jalr),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_br_taken(id_br_taken),
    .id_pred_taken(id_pred_taken),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_busy(mem_busy),
    .stall(s2), .freeze(fz2),
    .flush(fl2), .mispredict(mp2),
    .stall_remaining(rem2),
    .perf_stall_cyc(pst2),
    .perf_flush_cnt(pfl2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic wr, input logic ld,
                        input logic [4:0] rd);
    ex_reg_write = wr;
    ex_mem_read  = ld;
    ex_rd        = rd;
  endtask

  task automatic set_id(input logic br, input logic jal,
                        input logic jalr,
                        input logic u1, input logic [4:0] r1,
                        input logic u2, input logic [4:0] r2,
                        input logic tk, input logic pr);
    id_branch     = br;
    id_jal        = jal;
    id_jalr       = jalr;
    id_uses_rs1   = u1;
    id_rs1        = r1;
    id_uses_rs2   = u2;
    id_rs2        = r2;
    id_br_taken   = tk;
    id_pred_taken = pr;
  endtask

  task automatic clr();
    set_ex(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clr();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    set_ex(1, 1, 5);
    set_id(1, 0, 1, 1, 5, 1, 5, 1, 0);
    mem_busy = 1;
    #1;
    checks++;
    if ({stall, freeze, flush, misp} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000",
               {stall, freeze, flush, misp});
    end
    tick();
    checks++;
    if (rem !== 4'd0 || pst !== 16'd0 || pfl !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs rem=%0d pst=%0d pfl=%0d exp=0",
               rem, pst, pfl);
    end
    clr();
    rst = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle stall=%b flush=%b exp=0",
               stall, flush);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_ex(1, 1, 5);
    set_id(0, 0, 0, 1, 5, 1, 1, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b1 || flush !== 1'b0) begin
      failures++;
      $display("FAIL ldu_c1 stall=%b flush=%b exp=1,0",
               stall, flush);
    end
    tick();
    set_ex(0, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0 || rem !== 4'd0 || pst !== 16'd1) begin
      failures++;
      $display("FAIL ldu_c2 stall=%b rem=%0d pst=%0d exp=0,0,1",
               stall, rem, pst);
    end
    set_ex(1, 1, 5);
    set_id(0, 0, 0, 1, 1, 1, 5, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL ldu_rs2 stall=%b exp=1", stall);
    end
    tick();
    set_id(0, 0, 0, 0, 5, 0, 5, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL ldu_unused stall=%b exp=0", stall);
    end
  endtask

  task automatic test_ld_ctrl();
    do_reset();
    set_ex(1, 1, 5);
    set_id(1, 0, 0, 1, 5, 1, 0, 1, 0);
    #1;
    checks++;
    if (stall !== 1'b1 || flush !== 1'b0 || rem !== 4'd0) begin
      failures++;
      $display("FAIL ldc_c1 stall=%b flush=%b rem=%0d exp=1,0,0",
               stall, flush, rem);
    end
    tick();
    checks++;
    if (stall !== 1'b1 || flush !== 1'b0 || rem !== 4'd1) begin
      failures++;
      $display("FAIL ldc_c2 stall=%b flush=%b rem=%0d exp=1,0,1",
               stall, flush, rem);
    end
    tick();
    set_ex(0, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0 || rem !== 4'd0
        || flush !== 1'b1 || misp !== 1'b1) begin
      failures++;
      $display("FAIL ldc_c3 stall=%b rem=%0d fl=%b mp=%b exp=0,0,1,1",
               stall, rem, flush, misp);
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_ex(1, 0, 0);
    set_id(1, 0, 0, 1, 0, 1, 0, 1, 1);
    #1;
    checks++;
    if (stall !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL x0_alu stall=%b flush=%b exp=0,0",
               stall, flush);
    end
    set_ex(1, 1, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL x0_load stall=%b exp=0", stall);
    end
  endtask

  task automatic test_alu_ctrl();
    do_reset();
    set_ex(1, 0, 7);
    set_id(1, 0, 0, 1, 7, 1, 2, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL alu_br stall=%b exp=1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b1 || rem !== 4'd0) begin
      failures++;
      $display("FAIL alu_br_again stall=%b rem=%0d exp=1,0",
               stall, rem);
    end
    set_id(0, 0, 0, 1, 7, 1, 7, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL alu_add stall=%b exp=0", stall);
    end
    set_id(0, 0, 1, 1, 3, 1, 7, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0 || flush !== 1'b1 || misp !== 1'b0) begin
      failures++;
      $display("FAIL jalr_rs2 st=%b fl=%b mp=%b exp=0,1,0",
               stall, flush, misp);
    end
    set_ex(1, 1, 7);
    set_id(0, 0, 1, 1, 7, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b1 || flush !== 1'b0) begin
      failures++;
      $display("FAIL jalr_ld st=%b fl=%b exp=1,0", stall, flush);
    end
    tick();
    checks++;
    if (stall !== 1'b1 || rem !== 4'd1) begin
      failures++;
      $display("FAIL jalr_ld_c2 st=%b rem=%0d exp=1,1", stall, rem);
    end
    tick();
    clr();
  endtask

  task automatic test_flush();
    logic [3:0] pat [6];
    logic [2:0] exp [6];
    do_reset();
    // {jal, taken, pred, busy} -> {flush, misp, freeze}
    pat[0] = 4'b0100; exp[0] = 3'b110;
    pat[1] = 4'b0110; exp[1] = 3'b000;
    pat[2] = 4'b0010; exp[2] = 3'b110;
    pat[3] = 4'b1000; exp[3] = 3'b110;
    pat[4] = 4'b1010; exp[4] = 3'b000;
    pat[5] = 4'b0101; exp[5] = 3'b001;
    for (int i = 0; i < 6; i++) begin
      set_id(!pat[i][3], pat[i][3], 0, 1, 1, 1, 2,
             pat[i][2], pat[i][1]);
      mem_busy = pat[i][0];
      #1;
      checks++;
      if ({flush, misp, freeze} !== exp[i]) begin
        failures++;
        $display("FAIL flush_p%0d got=%b exp=%b",
                 i, {flush, misp, freeze}, exp[i]);
      end
      tick();
    end
    mem_busy = 0;
    clr();
    #1;
    checks++;
    if (pfl !== 16'd3 || pst !== 16'd0) begin
      failures++;
      $display("FAIL flush_cnt pfl=%0d pst=%0d exp=3,0", pfl, pst);
    end
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_ex(1, 1, 5);
    set_id(1, 0, 0, 1, 5, 1, 0, 1, 0);
    #1;
    checks++;
    if (stall !== 1'b1 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL mb_c1 stall=%b freeze=%b exp=1,0",
               stall, freeze);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_busy = 1;
      #1;
      checks++;
      if (freeze !== 1'b1 || stall !== 1'b0
          || flush !== 1'b0 || rem !== 4'd1) begin
        failures++;
        $display("FAIL mb_busy%0d fz=%b st=%b fl=%b rem=%0d exp=1,0,0,1",
                 i, freeze, stall, flush, rem);
      end
    end
    tick();
    mem_busy = 0;
    #1;
    checks++;
    if (stall !== 1'b1 || freeze !== 1'b0 || rem !== 4'd1) begin
      failures++;
      $display("FAIL mb_resume st=%b fz=%b rem=%0d exp=1,0,1",
               stall, freeze, rem);
    end
    tick();
    set_ex(0, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0 || pst !== 16'd2 || flush !== 1'b1) begin
      failures++;
      $display("FAIL mb_after st=%b pst=%0d fl=%b exp=0,2,1",
               stall, pst, flush);
    end
  endtask

  task automatic test_long_stall();
    logic       es;
    logic [3:0] er;
    do_reset();
    set_ex(1, 1, 5);
    set_id(1, 0, 0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_ex(0, 0, 0);
      es = (i < 3);
      er = (i == 1) ? 4'd2 : ((i == 2) ? 4'd1 : 4'd0);
      #1;
      checks++;
      if (s2 !== es || rem2 !== er) begin
        failures++;
        $display("FAIL long_c%0d stall=%b rem=%0d exp=%b,%0d",
                 i, s2, rem2, es, er);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_perf_sat();
    do_reset();
    set_ex(1, 1, 5);
    set_id(0, 0, 0, 1, 5, 0, 0, 0, 0);
    repeat (20) tick();
    checks++;
    if (pst2 !== 4'hF || pst !== 16'd20) begin
      failures++;
      $display("FAIL sat_a pst2=%0d pst=%0d exp=15,20", pst2, pst);
    end
    repeat (3) tick();
    checks++;
    if (pst2 !== 4'hF || pst !== 16'd23 || pfl2 !== 4'd0) begin
      failures++;
      $display("FAIL sat_hold pst2=%0d pst=%0d pfl2=%0d exp=15,23,0",
               pst2, pst, pfl2);
    end
    clr();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_ex(1, 1, 5);
    set_id(1, 0, 0, 1, 5, 0, 0, 1, 0);
    tick();
    #1;
    checks++;
    if (stall !== 1'b1 || rem !== 4'd1) begin
      failures++;
      $display("FAIL rms_pre stall=%b rem=%0d exp=1,1", stall, rem);
    end
    rst = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || rem !== 4'd0 || pst !== 16'd0
        || pfl !== 16'd0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL rms_rst st=%b rem=%0d pst=%0d pfl=%0d fl=%b exp=0",
               stall, rem, pst, pfl, flush);
    end
    tick();
    clr();
    rst = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || rem !== 4'd0) begin
      failures++;
      $display("FAIL rms_after st=%b rem=%0d exp=0,0", stall, rem);
    end
  endtask

  initial begin
    rst = 1;
    clr();
    test_reset();
    test_load_use();
    test_ld_ctrl();
    test_x0();
    test_alu_ctrl();
    test_flush();
    test_mem_busy();
    test_long_stall();
    test_perf_sat();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
